// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: fetch-side push channel, decode-side pop channel,
// flush redirect and occupancy.
interface fetch_queue_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_instr;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_instr;
    logic             out_ready;
    logic [CW-1:0]    count;

    // Master drives fetch entries, decode ready and flush.
    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr} between fetch and decode.
// Optional same-cycle pass-through when empty is enabled by FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    logic full;
    logic empty;
    logic byp;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    // Handshake decode; flush masks both sides and hides the head.
    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == CW'(0));
`ifdef FETCH_QUEUE_BYPASS_EN
        byp   = empty & bus.in_valid & ~bus.flush;
`else
        byp   = 1'b0;
`endif
        bus.in_ready  = ~full;
        bus.out_valid = (~empty | byp) & ~bus.flush;
        push  = bus.in_valid & ~full & ~bus.flush;
        pop   = bus.out_valid & bus.out_ready;
        // A bypassed entry consumed in the same cycle never touches storage.
        wr_en = push & ~(byp & bus.out_ready);
        rd_en = pop & ~byp;
        bus.count = count_q;
    end

    // Head presentation; zeros (NOP) whenever nothing valid is offered.
    always_comb begin
        bus.out_pc    = '0;
        bus.out_instr = '0;
        if (byp) begin
            bus.out_pc    = bus.in_pc;
            bus.out_instr = bus.in_instr;
        end else if (bus.out_valid) begin
            bus.out_pc    = pc_mem[rd_ptr];
            bus.out_instr = instr_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is intentionally not reset; empty-gating hides stale data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr]    <= bus.in_pc;
            instr_mem[wr_ptr] <= bus.in_instr;
        end
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the fetch stage and the decode stage of the 16-bit pipeline. It buffers up to DEPTH fetched {PC, instruction} pairs. Fetch keeps running while decode is stalled by hazards; fetch is frozen only when the queue is full. On a taken branch or jump, decode/execute raises `flush` and all buffered wrong-path instructions are discarded.

## Interface
- `WIDTH`, default `WORD_LEN` (16): width of PC and instruction words.
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `CW` (localparam): $clog2(DEPTH)+1, width of `count`.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — reset, asynchronous and active-high.
- `flush`  in  1  — discard all entries (branch/jump redirect).
- `in_valid`  in  1  — fetch presents a valid entry.
- `in_pc`  in  WIDTH  — PC of the fetched instruction.
- `in_instr`  in  WIDTH  — fetched instruction.
- `in_ready`  out  1  — queue can accept; fetch freeze = ~in_ready.
- `out_valid`  out  1  — head entry valid for decode.
- `out_pc`  out  WIDTH  — head PC.
- `out_instr`  out  WIDTH  — head instruction.
- `out_ready`  in  1  — decode consumes head this cycle (0 = decode stalled).
- `count`  out  CW  — current occupancy, 0..DEPTH.

## Operation
- Storage: circular array of DEPTH {pc, instr} entries.
  - `wr_ptr` and `rd_ptr` are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - `count` register tracks occupancy.
- Handshake definitions:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready.
- `in_ready` = (count != DEPTH). It does not depend on `out_ready`, so there is no combinational ready path. When full, a same-cycle pop does not enable a push.
- `out_valid` = (count != 0) & ~flush.
- `out_pc`/`out_instr` = head entry when `out_valid`, otherwise all zeros (NOP).
- Push only: write at `wr_ptr`, increment `wr_ptr` and `count`.
- Pop only: increment `rd_ptr`, decrement `count`.
- Push and pop in the same cycle (0 < count < DEPTH): both pointers advance, `count` unchanged, FIFO order preserved.
- Flush takes priority over push and pop:
  - Next cycle `wr_ptr` = `rd_ptr` = 0 and `count` = 0.
  - Any entry offered by fetch in the flush cycle is dropped, even if `in_ready` = 1. Fetch redirects in the same cycle, so the dropped entry is never needed.
- Storage contents are not reset; outputs are gated to zero when empty.

## Timing
- Reset (asynchronous, takes effect immediately on `rst` assertion):
  - `count` = 0, pointers = 0.
  - `out_valid` = 0, `out_pc` = 0, `out_instr` = 0.
  - `in_ready` = 1.
  - Applies also when reset is asserted mid-operation.
- Latency without bypass: an entry pushed at edge N is presented at the output from cycle N+1.
- Throughput: one push and one pop per cycle.
- Full: `in_ready` drops in the cycle after the edge that makes `count` = DEPTH. It rises in the cycle after the first pop.
- Flush: `out_valid` = 0 combinationally in the flush cycle, and `count` = 0 after the next edge. If `flush` is held, the queue stays empty.

## Configuration
- Macro: `FETCH_QUEUE_BYPASS_EN`.
- Defined: when `count` = 0, `in_valid` = 1 and `flush` = 0, the queue passes the input straight through in the same cycle:
  - `out_valid` = 1, `out_pc` = `in_pc`, `out_instr` = `in_instr`.
  - If `out_ready` = 1, the entry is consumed and not written; `count` stays 0.
  - If `out_ready` = 0, the entry is written normally.
- Undefined: no bypass; minimum fetch-to-decode latency is 1 cycle; the output path is purely registered.

## Test plan
- **Reset:** fill to `count` = 3, assert `rst` between edges → `count` = 0, `out_valid` = 0, `out_pc` = 0x0000, `in_ready` = 1 immediately, without waiting for a clock edge.
- **Fill and drain:**
  - With `out_ready` = 0, push PC 0x0000/0x0002/0x0004/0x0006 with instr 0x1111/0x2222/0x3333/0x4444 → `count` = 4, `in_ready` = 0.
  - A fifth push of 0x0008 is ignored.
  - With `out_ready` = 1, the outputs are 0x0000, 0x0002, 0x0004, 0x0006 on consecutive cycles, then `out_valid` = 0.
- **Concurrent push/pop with wrap:** hold `count` = 2 with continuous push and pop for 8 cycles → `count` stays 2 and the PC sequence is strictly increasing by 2 across pointer wrap.
- **Flush:** with `count` = 3, assert `flush` together with a push of PC 0x0040 → `out_valid` = 0 in that cycle, `count` = 0 next cycle, and 0x0040 never appears at the output.
- **Bypass (macro defined):**
  - Queue empty, push PC 0x0010 / instr 0xABCD with `out_ready` = 1 → `out_valid` = 1 and `out_pc` = 0x0010 in the same cycle, `count` stays 0.
  - Macro undefined, same stimulus → `out_valid` = 0 that cycle; `out_pc` = 0x0010 and `count` = 1 next cycle.
